// File: rtl/lieat_ifu_prdt_rspq_pkg.sv
// Shared IFU definitions: configuration widths, BHT counter encoding,
// opcode constants and the saturating-counter step function.
package lieat_ifu_prdt_rspq_pkg;

    localparam int XLEN_CFG    = 32;
    localparam int REG_IDX     = 5;
    localparam int BPU_IDX_CFG = 6;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_cnt_e;

    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    // One training step of a 2-bit saturating counter.
    function automatic logic [1:0] bht_cnt_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == BHT_ST) ? BHT_ST : cnt + 2'd1;
        end
        return (cnt == BHT_SNT) ? BHT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/lieat_general_dfflr.sv
// Generic load-enable flop with asynchronous active-high clear.
module lieat_general_dfflr #(
    parameter int DW = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    // Hold unless loaded; cleared to zero by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/lieat_ifu_bht.sv
// Branch history table of 2-bit saturating counters with a read port,
// a training port, and same-cycle write-to-read bypass.
module lieat_ifu_bht
    import lieat_ifu_prdt_rspq_pkg::*;
#(
    parameter int         BPU_IDX  = BPU_IDX_CFG,
    parameter logic [1:0] CNT_INIT = BHT_WNT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [BPU_IDX-1:0] rd_index,
    output logic [1:0]         rd_cnt,
    input  logic               upd_en,
    input  logic [BPU_IDX-1:0] upd_index,
    input  logic               upd_result
);

    localparam int ENTRIES = 1 << BPU_IDX;

    logic [1:0] cnt_q [ENTRIES];
    logic [1:0] cnt_d [ENTRIES];

    // Next table contents; reading from cnt_d gives the post-update bypass.
    always_comb begin
        cnt_d = cnt_q;
        if (upd_en) begin
            cnt_d[upd_index] = bht_cnt_next(cnt_q[upd_index], upd_result);
        end
        rd_cnt = cnt_d[rd_index];
    end

    // Counter storage, reinitialised to the weak state on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lieat_ifu_dec.sv
// Mini pre-decoder: classifies control-flow instructions and extracts
// the branch/jump immediate and the jalr source register.
module lieat_ifu_dec
    import lieat_ifu_prdt_rspq_pkg::*;
#(
    parameter int XLEN = XLEN_CFG
) (
    input  logic [XLEN-1:0]    inst,
    output logic               dec_rs1en,
    output logic [REG_IDX-1:0] dec_rs1,
    output logic               dec_jal,
    output logic               dec_bxx,
    output logic               dec_nojump,
    output logic               dec_fencei,
    output logic [XLEN-1:0]    dec_immb
);

    logic dec_jalr;

    // Opcode classification and immediate selection.
    always_comb begin
        dec_jal    = (inst[6:0] == OPC_JAL);
        dec_jalr   = (inst[6:0] == OPC_JALR);
        dec_bxx    = (inst[6:0] == OPC_BRANCH);
        dec_fencei = (inst[6:0] == OPC_MISC_MEM) && (inst[14:12] == 3'b001);
        dec_nojump = ~(dec_jal | dec_jalr | dec_bxx);
        dec_rs1en  = dec_jalr;
        dec_rs1    = inst[19:15];
        dec_immb   = '0;
        if (dec_bxx) begin
            dec_immb = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        end else if (dec_jal) begin
            dec_immb = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        end else if (dec_jalr) begin
            dec_immb = {{(XLEN-11){inst[31]}}, inst[30:20]};
        end
    end

endmodule

// File: rtl/lieat_ifu_prdt_rspq.sv
// Fetch-response queue: pre-decodes and predicts each response at enqueue
// and presents buffered entries to decode with a valid/ready handshake.
module lieat_ifu_prdt_rspq
    import lieat_ifu_prdt_rspq_pkg::*;
#(
    parameter int         XLEN     = XLEN_CFG,
    parameter int         BPU_IDX  = BPU_IDX_CFG,
    parameter int         DEPTH    = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               rsp_i_valid,
    output logic               rsp_i_ready,
    input  logic [XLEN-1:0]    rsp_i_pc,
    input  logic [XLEN-1:0]    rsp_i_inst,
    input  logic [BPU_IDX-1:0] rsp_i_index,
    output logic               rsp_o_valid,
    input  logic               rsp_o_ready,
    output logic [XLEN-1:0]    rsp_o_pc,
    output logic [XLEN-1:0]    rsp_o_inst,
    output logic [BPU_IDX-1:0] rsp_o_index,
    output logic               rsp_o_rs1en,
    output logic [REG_IDX-1:0] rsp_o_rs1,
    output logic               rsp_o_jal,
    output logic               rsp_o_bxx,
    output logic               rsp_o_nojump,
    output logic               rsp_o_fencei,
    output logic [XLEN-1:0]    rsp_o_immb,
    output logic               rsp_o_prdt_taken,
    input  logic               prdt_en,
    input  logic [BPU_IDX-1:0] prdt_index,
    input  logic               prdt_result
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    inst;
        logic [XLEN-1:0]    immb;
        logic [BPU_IDX-1:0] index;
        logic               rs1en;
        logic [REG_IDX-1:0] rs1;
        logic               jal;
        logic               bxx;
        logic               nojump;
        logic               fencei;
        logic               prdt_taken;
    } entry_t;

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    entry_t        new_ent, head;

    logic               dec_rs1en, dec_jal, dec_bxx, dec_nojump, dec_fencei;
    logic [REG_IDX-1:0] dec_rs1;
    logic [XLEN-1:0]    dec_immb;
    logic [1:0]         rd_cnt;

    lieat_ifu_dec #(.XLEN(XLEN)) u_dec (
        .inst       (rsp_i_inst),
        .dec_rs1en  (dec_rs1en),
        .dec_rs1    (dec_rs1),
        .dec_jal    (dec_jal),
        .dec_bxx    (dec_bxx),
        .dec_nojump (dec_nojump),
        .dec_fencei (dec_fencei),
        .dec_immb   (dec_immb)
    );

    lieat_ifu_bht #(.BPU_IDX(BPU_IDX), .CNT_INIT(CNT_INIT)) u_bht (
        .clock      (clock),
        .reset      (reset),
        .rd_index   (rsp_i_index),
        .rd_cnt     (rd_cnt),
        .upd_en     (prdt_en),
        .upd_index  (prdt_index),
        .upd_result (prdt_result)
    );

    // Handshake qualification and pointer/count next-state; flush wins.
    always_comb begin
        rsp_i_ready = (cnt_q != CW'(DEPTH));
        rsp_o_valid = (cnt_q != '0);
        push        = rsp_i_valid & rsp_i_ready & ~flush;
        pop         = rsp_o_valid & rsp_o_ready & ~flush;
        wptr_d      = flush ? '0 : wptr_q + PW'(1);
        rptr_d      = flush ? '0 : rptr_q + PW'(1);
        cnt_d       = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    lieat_general_dfflr #(.DW(PW)) u_wptr (
        .clock (clock), .reset (reset), .lden (flush | push), .dnxt (wptr_d), .qout (wptr_q)
    );
    lieat_general_dfflr #(.DW(PW)) u_rptr (
        .clock (clock), .reset (reset), .lden (flush | pop), .dnxt (rptr_d), .qout (rptr_q)
    );
    lieat_general_dfflr #(.DW(CW)) u_cnt (
        .clock (clock), .reset (reset), .lden (flush | push | pop), .dnxt (cnt_d), .qout (cnt_q)
    );

    // Assemble the enqueued entry; the prediction is frozen here.
    always_comb begin
        new_ent.pc         = rsp_i_pc;
        new_ent.inst       = rsp_i_inst;
        new_ent.immb       = dec_immb;
        new_ent.index      = rsp_i_index;
        new_ent.rs1en      = dec_rs1en;
        new_ent.rs1        = dec_rs1;
        new_ent.jal        = dec_jal;
        new_ent.bxx        = dec_bxx;
        new_ent.nojump     = dec_nojump;
        new_ent.fencei     = dec_fencei;
        new_ent.prdt_taken = dec_bxx & rd_cnt[1];
        mem_d              = mem_q;
        if (push) begin
            mem_d[wptr_q] = new_ent;
        end
    end

    // Queue storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Head payload, forced to zero while the queue is empty.
    always_comb begin
        head             = rsp_o_valid ? mem_q[rptr_q] : '0;
        rsp_o_pc         = head.pc;
        rsp_o_inst       = head.inst;
        rsp_o_index      = head.index;
        rsp_o_rs1en      = head.rs1en;
        rsp_o_rs1        = head.rs1;
        rsp_o_jal        = head.jal;
        rsp_o_bxx        = head.bxx;
        rsp_o_nojump     = head.nojump;
        rsp_o_fencei     = head.fencei;
        rsp_o_immb       = head.immb;
        rsp_o_prdt_taken = head.prdt_taken;
    end

endmodule

// File: tb/tb_lieat_ifu_prdt_rspq.sv
// Directed self-checking bench for the fetch-response prediction queue.
module tb_lieat_ifu_prdt_rspq;

    localparam logic [31:0] BEQ    = 32'h0000_0463;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] JAL    = 32'h0080_006F;
    localparam logic [31:0] JALR   = 32'h0000_8067;
    localparam logic [31:0] FENCEI = 32'h0000_100F;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        rsp_i_valid = 1'b0;
    logic        rsp_i_ready;
    logic [31:0] rsp_i_pc = '0;
    logic [31:0] rsp_i_inst = '0;
    logic [5:0]  rsp_i_index = '0;
    logic        rsp_o_valid;
    logic        rsp_o_ready = 1'b0;
    logic [31:0] rsp_o_pc, rsp_o_inst, rsp_o_immb;
    logic [5:0]  rsp_o_index;
    logic        rsp_o_rs1en;
    logic [4:0]  rsp_o_rs1;
    logic        rsp_o_jal, rsp_o_bxx, rsp_o_nojump, rsp_o_fencei, rsp_o_prdt_taken;
    logic        prdt_en = 1'b0;
    logic [5:0]  prdt_index = '0;
    logic        prdt_result = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    lieat_ifu_prdt_rspq dut (
        .clock            (clock),
        .reset            (reset),
        .flush            (flush),
        .rsp_i_valid      (rsp_i_valid),
        .rsp_i_ready      (rsp_i_ready),
        .rsp_i_pc         (rsp_i_pc),
        .rsp_i_inst       (rsp_i_inst),
        .rsp_i_index      (rsp_i_index),
        .rsp_o_valid      (rsp_o_valid),
        .rsp_o_ready      (rsp_o_ready),
        .rsp_o_pc         (rsp_o_pc),
        .rsp_o_inst       (rsp_o_inst),
        .rsp_o_index      (rsp_o_index),
        .rsp_o_rs1en      (rsp_o_rs1en),
        .rsp_o_rs1        (rsp_o_rs1),
        .rsp_o_jal        (rsp_o_jal),
        .rsp_o_bxx        (rsp_o_bxx),
        .rsp_o_nojump     (rsp_o_nojump),
        .rsp_o_fencei     (rsp_o_fencei),
        .rsp_o_immb       (rsp_o_immb),
        .rsp_o_prdt_taken (rsp_o_prdt_taken),
        .prdt_en          (prdt_en),
        .prdt_index       (prdt_index),
        .prdt_result      (prdt_result)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst, input logic [5:0] idx);
        rsp_i_valid = 1'b1;
        rsp_i_pc    = pc;
        rsp_i_inst  = inst;
        rsp_i_index = idx;
        tick();
        rsp_i_valid = 1'b0;
    endtask

    task automatic pop_one();
        rsp_o_ready = 1'b1;
        tick();
        rsp_o_ready = 1'b0;
    endtask

    task automatic train(input logic [5:0] idx, input logic res);
        prdt_en     = 1'b1;
        prdt_index  = idx;
        prdt_result = res;
        tick();
        prdt_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total_cnt++; if (rsp_o_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b want 0", rsp_o_valid); else pass_cnt++;
        total_cnt++; if (rsp_i_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %0b want 1", rsp_i_ready); else pass_cnt++;
        total_cnt++; if (rsp_o_pc !== 32'h0) $display("[TB] FAIL reset_pc: got %h want 0", rsp_o_pc); else pass_cnt++;
        total_cnt++; if (rsp_o_nojump !== 1'b0) $display("[TB] FAIL reset_nojump: got %0b want 0", rsp_o_nojump); else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_predict();
        push_one(32'h100, BEQ, 6'd5);
        total_cnt++; if (rsp_o_valid !== 1'b1) $display("[TB] FAIL beq_valid: got %0b want 1", rsp_o_valid); else pass_cnt++;
        total_cnt++; if (rsp_o_bxx !== 1'b1) $display("[TB] FAIL beq_bxx: got %0b want 1", rsp_o_bxx); else pass_cnt++;
        total_cnt++; if (rsp_o_prdt_taken !== 1'b0) $display("[TB] FAIL beq_init_prdt: got %0b want 0", rsp_o_prdt_taken); else pass_cnt++;
        total_cnt++; if (rsp_o_immb !== 32'd8) $display("[TB] FAIL beq_immb: got %h want 8", rsp_o_immb); else pass_cnt++;
        total_cnt++; if (rsp_o_pc !== 32'h100) $display("[TB] FAIL beq_pc: got %h want 100", rsp_o_pc); else pass_cnt++;
        total_cnt++; if (rsp_o_inst !== BEQ) $display("[TB] FAIL beq_inst: got %h want %h", rsp_o_inst, BEQ); else pass_cnt++;
        total_cnt++; if (rsp_o_index !== 6'd5) $display("[TB] FAIL beq_index: got %0d want 5", rsp_o_index); else pass_cnt++;
        total_cnt++; if (rsp_o_nojump !== 1'b0) $display("[TB] FAIL beq_nojump: got %0b want 0", rsp_o_nojump); else pass_cnt++;
        pop_one();
        total_cnt++; if (rsp_o_valid !== 1'b0) $display("[TB] FAIL pop_empty: got %0b want 0", rsp_o_valid); else pass_cnt++;
        total_cnt++; if (rsp_o_bxx !== 1'b0) $display("[TB] FAIL empty_payload_zero: got %0b want 0", rsp_o_bxx); else pass_cnt++;
        // 01 -> 10 -> 11
        train(6'd5, 1'b1);
        train(6'd5, 1'b1);
        push_one(32'h104, BEQ, 6'd5);
        total_cnt++; if (rsp_o_prdt_taken !== 1'b1) $display("[TB] FAIL prdt_after_2taken: got %0b want 1", rsp_o_prdt_taken); else pass_cnt++;
        pop_one();
        // saturate at 11, then 11 -> 10 -> 01 -> 00
        for (int i = 0; i < 6; i++) train(6'd5, 1'b1);
        for (int i = 0; i < 3; i++) train(6'd5, 1'b0);
        push_one(32'h108, BEQ, 6'd5);
        total_cnt++; if (rsp_o_prdt_taken !== 1'b0) $display("[TB] FAIL prdt_after_3nt: got %0b want 0", rsp_o_prdt_taken); else pass_cnt++;
        pop_one();
        // 00 -> 01 stays not-taken, 01 -> 10 becomes taken
        train(6'd5, 1'b1);
        push_one(32'h10C, BEQ, 6'd5);
        total_cnt++; if (rsp_o_prdt_taken !== 1'b0) $display("[TB] FAIL prdt_from_snt: got %0b want 0", rsp_o_prdt_taken); else pass_cnt++;
        pop_one();
        train(6'd5, 1'b1);
        push_one(32'h110, BEQ, 6'd5);
        total_cnt++; if (rsp_o_prdt_taken !== 1'b1) $display("[TB] FAIL prdt_to_wt: got %0b want 1", rsp_o_prdt_taken); else pass_cnt++;
        pop_one();
        push_one(32'h114, NOP, 6'd5);
        total_cnt++; if (rsp_o_prdt_taken !== 1'b0) $display("[TB] FAIL nop_prdt: got %0b want 0", rsp_o_prdt_taken); else pass_cnt++;
        total_cnt++; if (rsp_o_nojump !== 1'b1) $display("[TB] FAIL nop_nojump: got %0b want 1", rsp_o_nojump); else pass_cnt++;
        pop_one();
    endtask

    task automatic test_bypass();
        prdt_en     = 1'b1;
        prdt_index  = 6'd9;
        prdt_result = 1'b1;
        push_one(32'h180, BEQ, 6'd9);
        prdt_en = 1'b0;
        total_cnt++; if (rsp_o_prdt_taken !== 1'b1) $display("[TB] FAIL bypass_prdt: got %0b want 1", rsp_o_prdt_taken); else pass_cnt++;
        pop_one();
    endtask

    task automatic test_full();
        logic [31:0] exp_pc;
        rsp_o_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h200 + 32'(i) * 32'h10;
            push_one(exp_pc, NOP, 6'd1);
        end
        total_cnt++; if (rsp_i_ready !== 1'b0) $display("[TB] FAIL full_ready: got %0b want 0", rsp_i_ready); else pass_cnt++;
        push_one(32'h2F0, NOP, 6'd1);
        total_cnt++; if (rsp_o_pc !== 32'h200) $display("[TB] FAIL full_head: got %h want 200", rsp_o_pc); else pass_cnt++;
        // pop while full with a push offered: the push must be refused
        rsp_o_ready = 1'b1;
        push_one(32'h2F4, NOP, 6'd1);
        rsp_o_ready = 1'b0;
        total_cnt++; if (rsp_i_ready !== 1'b1) $display("[TB] FAIL ready_after_pop: got %0b want 1", rsp_i_ready); else pass_cnt++;
        push_one(32'h240, NOP, 6'd1);
        total_cnt++; if (rsp_i_ready !== 1'b0) $display("[TB] FAIL refull_ready: got %0b want 0", rsp_i_ready); else pass_cnt++;
        for (int i = 1; i < 5; i++) begin
            exp_pc = 32'h200 + 32'(i) * 32'h10;
            total_cnt++; if (rsp_o_pc !== exp_pc) $display("[TB] FAIL wrap_order_%0d: got %h want %h", i, rsp_o_pc, exp_pc); else pass_cnt++;
            pop_one();
        end
        total_cnt++; if (rsp_o_valid !== 1'b0) $display("[TB] FAIL drained_valid: got %0b want 0", rsp_o_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        rsp_o_ready = 1'b1;
        rsp_i_inst  = NOP;
        rsp_i_index = 6'd2;
        for (int i = 0; i < 5; i++) begin
            exp_pc      = 32'h500 + 32'(i) * 32'h4;
            rsp_i_valid = 1'b1;
            rsp_i_pc    = exp_pc;
            tick();
            total_cnt++; if (rsp_o_pc !== exp_pc || rsp_o_valid !== 1'b1) $display("[TB] FAIL b2b_%0d: got %h/%0b want %h/1", i, rsp_o_pc, rsp_o_valid, exp_pc); else pass_cnt++;
        end
        rsp_i_valid = 1'b0;
        tick();
        rsp_o_ready = 1'b0;
        total_cnt++; if (rsp_o_valid !== 1'b0) $display("[TB] FAIL b2b_drain: got %0b want 0", rsp_o_valid); else pass_cnt++;
    endtask

    task automatic test_flush();
        push_one(32'h600, NOP, 6'd1);
        push_one(32'h610, NOP, 6'd1);
        push_one(32'h620, NOP, 6'd1);
        flush       = 1'b1;
        prdt_en     = 1'b1;
        prdt_index  = 6'd20;
        prdt_result = 1'b1;
        push_one(32'h6F0, NOP, 6'd1);
        flush   = 1'b0;
        prdt_en = 1'b0;
        total_cnt++; if (rsp_o_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %0b want 0", rsp_o_valid); else pass_cnt++;
        total_cnt++; if (rsp_i_ready !== 1'b1) $display("[TB] FAIL flush_ready: got %0b want 1", rsp_i_ready); else pass_cnt++;
        push_one(32'h700, BEQ, 6'd20);
        total_cnt++; if (rsp_o_pc !== 32'h700) $display("[TB] FAIL post_flush_head: got %h want 700", rsp_o_pc); else pass_cnt++;
        total_cnt++; if (rsp_o_prdt_taken !== 1'b1) $display("[TB] FAIL flush_train_kept: got %0b want 1", rsp_o_prdt_taken); else pass_cnt++;
        pop_one();
        total_cnt++; if (rsp_o_valid !== 1'b0) $display("[TB] FAIL flush_count_zero: got %0b want 0", rsp_o_valid); else pass_cnt++;
    endtask

    task automatic test_jal_reset();
        push_one(32'h800, JAL, 6'd5);
        push_one(32'h804, JALR, 6'd5);
        push_one(32'h808, FENCEI, 6'd5);
        total_cnt++; if (rsp_o_jal !== 1'b1) $display("[TB] FAIL jal_flag: got %0b want 1", rsp_o_jal); else pass_cnt++;
        total_cnt++; if (rsp_o_prdt_taken !== 1'b0) $display("[TB] FAIL jal_prdt: got %0b want 0", rsp_o_prdt_taken); else pass_cnt++;
        total_cnt++; if (rsp_o_immb !== 32'd8) $display("[TB] FAIL jal_immb: got %h want 8", rsp_o_immb); else pass_cnt++;
        total_cnt++; if (rsp_o_bxx !== 1'b0) $display("[TB] FAIL jal_bxx: got %0b want 0", rsp_o_bxx); else pass_cnt++;
        pop_one();
        total_cnt++; if (rsp_o_rs1en !== 1'b1 || rsp_o_rs1 !== 5'd1) $display("[TB] FAIL jalr_rs1: got %0b/%0d want 1/1", rsp_o_rs1en, rsp_o_rs1); else pass_cnt++;
        total_cnt++; if (rsp_o_nojump !== 1'b0) $display("[TB] FAIL jalr_nojump: got %0b want 0", rsp_o_nojump); else pass_cnt++;
        pop_one();
        total_cnt++; if (rsp_o_fencei !== 1'b1 || rsp_o_nojump !== 1'b1) $display("[TB] FAIL fencei_flags: got %0b/%0b want 1/1", rsp_o_fencei, rsp_o_nojump); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (rsp_o_valid !== 1'b0) $display("[TB] FAIL async_reset_valid: got %0b want 0", rsp_o_valid); else pass_cnt++;
        total_cnt++; if (rsp_i_ready !== 1'b1) $display("[TB] FAIL async_reset_ready: got %0b want 1", rsp_i_ready); else pass_cnt++;
        #1 reset = 1'b0;
        tick();
        // counters at index 5 and 9 were 10 before reset; now back to 01
        push_one(32'h900, BEQ, 6'd5);
        total_cnt++; if (rsp_o_prdt_taken !== 1'b0) $display("[TB] FAIL reset_cnt5: got %0b want 0", rsp_o_prdt_taken); else pass_cnt++;
        pop_one();
        push_one(32'h904, BEQ, 6'd9);
        total_cnt++; if (rsp_o_prdt_taken !== 1'b0) $display("[TB] FAIL reset_cnt9: got %0b want 0", rsp_o_prdt_taken); else pass_cnt++;
        pop_one();
    endtask

    initial begin
        test_reset();
        test_predict();
        test_bypass();
        test_full();
        test_back_to_back();
        test_flush();
        test_jal_reset();
        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
